// File: rtl/io_ctrl.sv
// io_ctrl: sequences the STIN/LOUT I/O instructions between the core and the
// external switches/LEDs.
//   STIN (read_in)   - stalls the PC and runs a valid/ready input handshake. It then
//                      issues one register-file write carrying the captured word.
//   LOUT (write_out) - loads the LED register and raises out_valid. It stalls only
//                      when a previous word is still unacknowledged.
// Optional feature macro: IO_TIMEOUT_EN. It aborts a STIN that waits TIMEOUT cycles
// for in_valid, writes 0 to the register file and sets the sticky timeout flag.
// Ports:
//   clk, n_reset                   clock, asynchronous active-low reset
//   read_in, write_out             decoder strobes (sampled only in idle)
//   out_data                       register-file read data to display
//   in_data, in_valid, in_ready    input handshake
//   out_reg, out_valid, out_ack    output handshake
//   stall                          hold PC / suppress core register write
//   rf_we, rf_wdata                STIN register-file write port
//   timeout                        sticky STIN-abort flag
module io_ctrl #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         read_in,
    input  logic         write_out,
    input  logic [W-1:0] out_data,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_reg,
    output logic         out_valid,
    input  logic         out_ack,
    output logic         stall,
    output logic         rf_we,
    output logic [W-1:0] rf_wdata,
    output logic         timeout
);

    typedef enum logic [1:0] {StIdle, StWaitIn, StWrite, StWaitAck} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   out_reg_q, out_reg_d;
    logic [W-1:0]   rf_wdata_q, rf_wdata_d;
    logic           out_valid_q, out_valid_d;
    logic           stall_c, in_ready_c, rf_we_c;
    logic           capture, abort, load;
    logic           expire;

`ifdef IO_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Counts completed WAIT_IN cycles. The last allowed cycle is TIMEOUT-1.
    assign expire = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q | abort;
        if (state_q == StWaitIn && state_d == StWaitIn) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        in_ready_c = 1'b0;
        rf_we_c    = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        load       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // read_in has priority over an (illegal) simultaneous write_out
                if (read_in) begin
                    stall_c    = 1'b1;
                    in_ready_c = 1'b1;
                    if (in_valid) begin
                        capture = 1'b1;
                        state_d = StWrite;
                    end else begin
                        state_d = StWaitIn;
                    end
                end else if (write_out) begin
                    if (out_valid_q && !out_ack) begin
                        stall_c = 1'b1;
                        state_d = StWaitAck;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            StWaitIn: begin
                stall_c    = 1'b1;
                in_ready_c = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = StWrite;
                end else if (expire) begin
                    abort   = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                stall_c = 1'b1;
                rf_we_c = 1'b1;
                state_d = StIdle;
            end
            StWaitAck: begin
                // Release the PC on the ack edge so the LOUT is not re-issued
                if (out_ack) begin
                    load    = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rf_wdata_d  = rf_wdata_q;
        out_reg_d   = out_reg_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            rf_wdata_d = in_data;
        end else if (abort) begin
            rf_wdata_d = '0;
        end
        // A load in the same cycle as an ack wins
        if (load) begin
            out_reg_d   = out_data;
            out_valid_d = 1'b1;
        end else if (out_ack) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            out_reg_q   <= '0;
            out_valid_q <= 1'b0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_reg_q   <= out_reg_d;
            out_valid_q <= out_valid_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    // Gate the decoded strobes so they drop the moment reset asserts
    assign stall     = stall_c & n_reset;
    assign in_ready  = in_ready_c & n_reset;
    assign rf_we     = rf_we_c & n_reset;
    assign out_reg   = out_reg_q;
    assign out_valid = out_valid_q;
    assign rf_wdata  = rf_wdata_q;

endmodule
